// File: rtl/note_arbiter_if.sv
// Request/response bundle for the amplifier note-channel arbiter.
// The arbiter attaches through the slave modport; the upstream and downstream logic use the master modport.
interface note_arbiter_if;
  logic       live_valid;
  logic [2:0] live_octave;
  logic [2:0] live_note;
  logic       pb_valid;
  logic [2:0] pb_octave;
  logic [2:0] pb_note;
  logic       pb_ready;
  logic       met_en;
  logic       met_tick;
  logic [2:0] octave_out;
  logic [2:0] note_out;
  logic [1:0] src_out;
  logic       busy;

  modport master (
    output live_valid, live_octave, live_note,
    output pb_valid, pb_octave, pb_note,
    output met_en, met_tick,
    input  pb_ready, octave_out, note_out, src_out, busy
  );

  modport slave (
    input  live_valid, live_octave, live_note,
    input  pb_valid, pb_octave, pb_note,
    input  met_en, met_tick,
    output pb_ready, octave_out, note_out, src_out, busy
  );
endinterface

// File: rtl/note_arbiter.sv
// Fixed-priority owner of the single amplifier note channel: live > metronome > playback.
// Each grant holds its note for HOLD_x cycles, then the channel returns to silence.
module note_arbiter #(
  parameter int CNT_W     = 20,
  parameter int HOLD_LIVE = 1000000,
  parameter int HOLD_PB   = 250000,
  parameter int HOLD_MET  = 20000,
  parameter int MET_OCT   = 7,
  parameter int MET_NOTE  = 1
) (
  input logic         clk_1M,
  input logic         rst,
  note_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, LIVE = 2'd1, PB = 2'd2, MET = 2'd3} state_t;

  localparam logic [CNT_W-1:0] LD_LIVE = CNT_W'(HOLD_LIVE - 1);
  localparam logic [CNT_W-1:0] LD_PB   = CNT_W'(HOLD_PB - 1);
  localparam logic [CNT_W-1:0] LD_MET  = CNT_W'(HOLD_MET - 1);
  localparam logic [2:0]       M_OCT   = 3'(MET_OCT);
  localparam logic [2:0]       M_NOTE  = 3'(MET_NOTE);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       oct_n, note_n;
  logic             pb_ready_n;
  logic             met_pend, met_pend_n;
  logic             live_req, met_req, grant_met;

  assign live_req = bus.live_valid && (bus.live_note != 3'd0);
  // A tick arriving in an idle cycle competes immediately, so it beats a simultaneous playback note.
  assign met_req  = bus.met_en && (met_pend || bus.met_tick);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    oct_n      = bus.octave_out;
    note_n     = bus.note_out;
    pb_ready_n = 1'b0;
    grant_met  = 1'b0;
    if (live_req) begin
      state_n = LIVE;
      cnt_n   = LD_LIVE;
      oct_n   = bus.live_octave;
      note_n  = bus.live_note;
    end else if (state != IDLE) begin
      if (cnt != '0) begin
        cnt_n = cnt - 1'b1;
      end else begin
        state_n = IDLE;
        oct_n   = 3'd0;
        note_n  = 3'd0;
      end
    end else if (met_req) begin
      state_n   = MET;
      cnt_n     = LD_MET;
      oct_n     = M_OCT;
      note_n    = M_NOTE;
      grant_met = 1'b1;
    end else if (bus.pb_valid) begin
      state_n    = PB;
      cnt_n      = LD_PB;
      oct_n      = bus.pb_octave;
      note_n     = bus.pb_note;
      pb_ready_n = 1'b1;
    end

    met_pend_n = met_pend;
    if (!bus.met_en)     met_pend_n = 1'b0;
    else if (grant_met)  met_pend_n = 1'b0;
    else if (bus.met_tick) met_pend_n = 1'b1;
  end

  always_ff @(posedge clk_1M) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      met_pend       <= 1'b0;
      bus.octave_out <= 3'd0;
      bus.note_out   <= 3'd0;
      bus.pb_ready   <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      met_pend       <= met_pend_n;
      bus.octave_out <= oct_n;
      bus.note_out   <= note_n;
      bus.pb_ready   <= pb_ready_n;
    end
  end

  assign bus.src_out = state;
  assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_note_arbiter.sv
// Directed plus randomized bench for note_arbiter against a cycle-level reference model
// expressed as owner / cycles-remaining / pending-click.
module tb_note_arbiter;
  localparam int CNT_W = 8;
  localparam int H_LIVE = 40;
  localparam int H_PB = 25;
  localparam int H_MET = 12;

  logic clk_1M = 1'b0;
  logic rst;
  note_arbiter_if bus();

  note_arbiter #(
    .CNT_W(CNT_W), .HOLD_LIVE(H_LIVE), .HOLD_PB(H_PB), .HOLD_MET(H_MET),
    .MET_OCT(7), .MET_NOTE(1)
  ) dut (
    .clk_1M(clk_1M),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk_1M = ~clk_1M;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model: owner (0 idle,1 live,2 pb,3 met), cycles left in the note, pending click
  logic [1:0] own = 2'd0;
  int         rem = 0;
  bit         pend = 1'b0;
  logic [2:0] eo = 3'd0, en = 3'd0;
  bit         epr = 1'b0;

  task automatic model_edge();
    bit lreq, mreq, took_met;
    lreq = bus.live_valid && (bus.live_note != 3'd0);
    mreq = bus.met_en && (pend || bus.met_tick);
    took_met = 1'b0;
    epr = 1'b0;
    if (rst) begin
      own = 2'd0; rem = 0; pend = 1'b0; eo = 3'd0; en = 3'd0;
      return;
    end
    if (lreq) begin
      own = 2'd1; rem = H_LIVE; eo = bus.live_octave; en = bus.live_note;
    end else if (own != 2'd0) begin
      rem = rem - 1;
      if (rem == 0) begin own = 2'd0; eo = 3'd0; en = 3'd0; end
    end else if (mreq) begin
      own = 2'd3; rem = H_MET; eo = 3'd7; en = 3'd1; took_met = 1'b1;
    end else if (bus.pb_valid) begin
      own = 2'd2; rem = H_PB; eo = bus.pb_octave; en = bus.pb_note; epr = 1'b1;
    end
    if (!bus.met_en)      pend = 1'b0;
    else if (took_met)    pend = 1'b0;
    else if (bus.met_tick) pend = 1'b1;
  endtask

  task automatic check(input string tag);
    logic [9:0] obs, exp;
    obs = {bus.src_out, bus.octave_out, bus.note_out, bus.busy, bus.pb_ready};
    exp = {own, eo, en, (own != 2'd0), epr};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed src/oct/note/busy/rdy=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // one clock: model follows the edge, outputs compared mid-cycle, pulses retired, pb source drops on accept
  task automatic cycle(input string tag);
    @(posedge clk_1M);
    model_edge();
    cyc++;
    @(negedge clk_1M);
    check(tag);
    bus.live_valid = 1'b0;
    bus.met_tick   = 1'b0;
    if (epr) bus.pb_valid = 1'b0;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic live(input logic [2:0] o, input logic [2:0] n);
    bus.live_valid = 1'b1; bus.live_octave = o; bus.live_note = n;
  endtask

  task automatic pb(input logic [2:0] o, input logic [2:0] n);
    bus.pb_valid = 1'b1; bus.pb_octave = o; bus.pb_note = n;
  endtask

  initial begin
    rst = 1'b1;
    bus.live_valid = 1'b0; bus.live_octave = 3'd0; bus.live_note = 3'd0;
    bus.pb_valid = 1'b0; bus.pb_octave = 3'd0; bus.pb_note = 3'd0;
    bus.met_en = 1'b0; bus.met_tick = 1'b0;
    @(negedge clk_1M);
    run(3, "reset");
    rst = 1'b0;

    // playback grant, single-cycle accept, silence after H_PB
    pb(3'd4, 3'd3);
    run(H_PB + 5, "pb_basic");

    // live preempts an active playback note
    pb(3'd2, 3'd6);
    run(10, "pb_pre");
    live(3'd5, 3'd6);
    run(H_LIVE + 5, "live_preempt");

    // tick and playback together in idle: click first, one idle cycle, then playback
    bus.met_en = 1'b1;
    bus.met_tick = 1'b1;
    pb(3'd2, 3'd5);
    run(H_MET + H_PB + 6, "met_vs_pb");

    // live with note 0 is ignored
    live(3'd3, 3'd0);
    run(4, "live_note0");

    // two ticks during live produce exactly one click afterwards
    live(3'd3, 3'd2);
    run(5, "live_ticks");
    bus.met_tick = 1'b1;
    run(8, "live_ticks");
    bus.met_tick = 1'b1;
    run(H_LIVE + H_MET + 6, "live_ticks");

    // reset mid-live, pb held through it, granted right after release
    live(3'd6, 3'd4);
    run(6, "rst_mid");
    bus.met_tick = 1'b1;
    run(2, "rst_mid");
    pb(3'd1, 3'd1);
    rst = 1'b1;
    run(2, "rst_mid");
    rst = 1'b0;
    run(H_PB + 4, "rst_release");

    // retrigger near the end of a live note
    live(3'd2, 3'd2);
    cycle("retrig");
    for (int i = 0; i < H_LIVE && rem != 6; i++) cycle("retrig");
    live(3'd1, 3'd7);
    run(H_LIVE + 5, "retrig");

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) live(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 29) == 0) bus.met_tick = 1'b1;
      if ($urandom_range(0, 199) == 0) bus.met_en = ~bus.met_en;
      if (!bus.pb_valid && $urandom_range(0, 9) == 0) pb(3'($urandom_range(0, 7)), 3'($urandom_range(1, 7)));
      rst = ($urandom_range(0, 399) == 0);
      cycle("random");
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/note_arbiter.md
Name: note_arbiter

Overview:
- Owns the single amplifier note channel (octave_out/note_out) and shares it between three requesters: live keyboard events, recorded playback notes, and a metronome click.
- Grants by fixed priority: live > metronome > playback. Live preempts any active note; the others wait for idle.
- Each grant holds the note for a per-source number of clk_1M cycles, then returns the channel to silence (0/0).
- Sits between the key/octave logic, the playback buffer reader and the amplifier driver.

Parameters:
- CNT_W, 20, width of the hold counter; every HOLD_* value must be ≤ 2^CNT_W−1 and ≥ 1.
- HOLD_LIVE, 1000000, cycles a live note sounds (1 s at 1 MHz).
- HOLD_PB, 250000, cycles a playback note sounds.
- HOLD_MET, 20000, cycles a metronome click sounds.
- MET_OCT, 7, octave used for the click.
- MET_NOTE, 1, note used for the click.

Ports:
- clk_1M in 1 — 1 MHz clock.
- rst in 1 — synchronous, active-high reset.
- live_valid in 1 — single-cycle live note event.
- live_octave in 3 — octave of the live event.
- live_note in 3 — note 1..7 of the live event; 0 means no request.
- pb_valid in 1 — playback note available; source holds it and its data until pb_ready.
- pb_octave in 3 — playback octave.
- pb_note in 3 — playback note.
- pb_ready out 1 — one-cycle accept pulse for the playback note.
- met_en in 1 — metronome enable.
- met_tick in 1 — one-cycle beat pulse.
- octave_out out 3 — octave to the amplifier.
- note_out out 3 — note to the amplifier; 0 means silent.
- src_out out 2 — current owner: 0 idle, 1 live, 2 playback, 3 metronome.
- busy out 1 — asserted when src_out ≠ 0.

Behaviour:
- Reset: all outputs register to 0, state IDLE, hold counter 0, met_pend 0. Reset applies mid-note and silences the channel on the next edge.
- Reset vs. requests: a pb_valid held through reset is re-arbitrated after reset deasserts. A live or met event in a reset cycle is lost.
- Live request: live_req = live_valid && live_note ≠ 0. An event with note 0 is ignored.
- Metronome pending flag: met_pend is set by met_tick && met_en and cleared when MET is granted or when met_en = 0.
  - A tick arriving while met_pend = 1 is dropped; at most one click is pending.
- States: IDLE, LIVE, PB, MET. src_out is the state encoding; all outputs are registered.
- Grant latency: a request sampled at edge N drives its outputs from edge N+1.
- Any state, live_req:
  - go to LIVE and drive live_octave/live_note; counter ← HOLD_LIVE−1.
  - This retriggers when already in LIVE. A preempted PB note is abandoned, not re-queued. A preempted MET click is lost.
- IDLE, no live_req, met_pend: go to MET and drive MET_OCT/MET_NOTE; counter ← HOLD_MET−1.
- IDLE, no live_req, no met_pend, pb_valid:
  - go to PB and drive pb_octave/pb_note; counter ← HOLD_PB−1.
  - pb_ready = 1 for exactly that first PB cycle.
- LIVE/PB/MET with no live_req:
  - counter ≠ 0: decrement.
  - counter = 0: go to IDLE with octave_out = 0 and note_out = 0.
  - A note therefore sounds for exactly HOLD_x cycles.
- IDLE always lasts at least one cycle between non-live grants. This lets a pending click win over the next playback note.
- pb_ready is never asserted outside the PB grant cycle and never in a cycle where live_req is true.
- Simultaneous requests in IDLE:
  - live + pb: live wins; pb_valid stays pending.
  - met_pend + pb: MET wins.
  - live + met_tick: LIVE wins; met_pend is set and serviced after LIVE ends.
- met_en deasserted during MET: the current click completes; the pending flag is cleared.

Test Plan:
- Reset, then one pb_valid with oct 4, note 3 held until pb_ready → the next edge gives src_out=2 and outputs 4/3. pb_ready is high exactly 1 cycle. Outputs return to 0/0 after 250000 cycles; busy then falls.
- In PB, a live_valid with oct 5, note 6 arrives at cycle 1000 → the next edge gives src_out=1 and 5/6. The PB note is not resumed. Silence follows 1000000 cycles later.
- met_en=1 and a met_tick in the same cycle as pb_valid while IDLE → MET (7/1) for 20000 cycles, then 1 idle cycle, then PB with its pb_ready pulse.
- A live event with live_note=0 in IDLE → no state change, outputs stay 0/0. Two met_ticks during LIVE → exactly one click after LIVE ends.
- rst asserted mid-LIVE → the next edge gives all outputs 0 and met_pend cleared. A held pb_valid is granted 1 cycle after rst deasserts.
- A second live event at hold counter = 5 → the note changes next edge and the counter reloads to HOLD_LIVE−1 (retrigger), total hold extended.
